// File: rtl/tick_sched_pkg.sv
// ---------------------------------------------------------------------------
// tick_sched_pkg
// Shared types and constants for the tick scheduler slice.
//   ch_state_e  : per-channel FSM states (IDLE / ARM / RUN)
//   cfg_state_e : configuration port FSM states (C_IDLE / C_APPLY)
//   CH_*        : conventional channel assignments for the game logic
//   satExp      : clamps a requested exponent to the prescaler width
// ---------------------------------------------------------------------------
package tick_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } ch_state_e;

    typedef enum logic {
        C_IDLE  = 1'b0,
        C_APPLY = 1'b1
    } cfg_state_e;

    localparam int CH_BULLET = 0;
    localparam int CH_ENEMY  = 1;
    localparam int CH_DISP   = 2;
    localparam int CH_SPARE  = 3;

    // A period longer than the prescaler can express is meaningless, so
    // oversized exponents collapse to the full counter width.
    function automatic int satExp(input int expVal, input int maxExp);
        return (expVal > maxExp) ? maxExp : expVal;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// ---------------------------------------------------------------------------
// tick_channel
// One tick channel: exponent register, mask compare against the shared
// prescaler and the IDLE/ARM/RUN FSM that produces a registered one-cycle
// tick at a power-of-two period.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   cnt_i           shared prescaler value
//   pause_i         freeze: no state advance out of ARM, no ticks
//   wr_i            apply a configuration to this channel this cycle
//   wrExp_i         new exponent (already saturated by the caller)
//   wrEn_i          1 = (re)arm the channel, 0 = stop it
//   tick_o          registered one-cycle enable pulse
//   active_o        channel is in RUN
// ---------------------------------------------------------------------------
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int EXP_W       = 5,
    parameter int DEFAULT_EXP = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             pause_i,
    input  logic             wr_i,
    input  logic [EXP_W-1:0] wrExp_i,
    input  logic             wrEn_i,
    output logic             tick_o,
    output logic             active_o
);

    ch_state_e        state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] mask;

    // Mask has the low exp bits set; exponents at or above the counter
    // width simply give an all-ones mask.
    always_comb begin
        mask = '0;
        for (int b = 0; b < CNT_W; b++) begin
            mask[b] = (b < int'(exp_q));
        end
    end

    // Next-state logic. A configuration write takes priority over any tick
    // match in the same cycle, so a write always yields tick_d = 0.
    // ARM waits for the start of a period so the first RUN period is full
    // length; only a zero mask (tick every cycle) ticks on the arming cycle.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        tick_d  = 1'b0;
        if (wr_i) begin
            if (wrEn_i) begin
                exp_d   = wrExp_i;
                state_d = ARM;
            end else begin
                state_d = IDLE;
            end
        end else if (!pause_i) begin
            unique case (state_q)
                ARM: begin
                    if ((cnt_i & mask) == '0) begin
                        state_d = RUN;
                        tick_d  = (mask == '0);
                    end
                end
                RUN: begin
                    tick_d = ((cnt_i & mask) == mask);
                end
                default: begin
                end
            endcase
        end
    end

    // State, exponent and tick registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            exp_q   <= EXP_W'(DEFAULT_EXP);
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o   = tick_q;
    assign active_o = (state_q == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler
// Shared free-running prescaler feeding NCH tick channels, each producing a
// one-cycle clock enable at its own power-of-two period. Channels are
// configured at runtime through a two-cycle valid/ready port.
// Ports:
//   in_clk, reset_n      clock, asynchronous active-low reset
//   pause                freeze prescaler, suppress ticks
//   cfg_valid/cfg_ready  configuration handshake
//   cfg_ch               target channel (out-of-range values are ignored)
//   cfg_exp              period exponent, period = 2^cfg_exp cycles
//   cfg_en               1 = enable channel, 0 = disable channel
//   tick                 per-channel one-cycle enable
//   ch_active            per-channel RUN indication
// ---------------------------------------------------------------------------
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 24,
    parameter int EXP_W       = 5,
    parameter int DEFAULT_EXP = 20
) (
    input  logic                                 in_clk,
    input  logic                                 reset_n,
    input  logic                                 pause,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
    input  logic [EXP_W-1:0]                     cfg_exp,
    input  logic                                 cfg_en,
    output logic [NCH-1:0]                       tick,
    output logic [NCH-1:0]                       ch_active
);

    localparam int CH_W = $clog2(NCH > 1 ? NCH : 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_state_e       cfgState_q, cfgState_d;
    logic [CH_W-1:0]  latCh_q, latCh_d;
    logic [EXP_W-1:0] latExp_q, latExp_d;
    logic             latEn_q, latEn_d;
    logic             apply;

    // Prescaler wraps naturally at 2^CNT_W; every period divides that, so
    // the wrap never disturbs channel phase.
    always_comb begin
        cnt_d = pause ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Config FSM: latch a request in C_IDLE, write it to the channel in
    // C_APPLY. Exponent saturation happens at latch time so the channel
    // never sees an out-of-range value.
    always_comb begin
        cfgState_d = cfgState_q;
        latCh_d    = latCh_q;
        latExp_d   = latExp_q;
        latEn_d    = latEn_q;
        cfg_ready  = 1'b0;
        apply      = 1'b0;
        unique case (cfgState_q)
            C_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    latCh_d    = cfg_ch;
                    latExp_d   = EXP_W'(satExp(int'(cfg_exp), CNT_W));
                    latEn_d    = cfg_en;
                    cfgState_d = C_APPLY;
                end
            end
            C_APPLY: begin
                apply      = 1'b1;
                cfgState_d = C_IDLE;
            end
            default: begin
                cfgState_d = C_IDLE;
            end
        endcase
    end

    // Prescaler and config registers.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            cfgState_q <= C_IDLE;
            latCh_q    <= '0;
            latExp_q   <= '0;
            latEn_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cfgState_q <= cfgState_d;
            latCh_q    <= latCh_d;
            latExp_q   <= latExp_d;
            latEn_q    <= latEn_d;
        end
    end

    // A latched channel index >= NCH matches no instance, so such
    // requests are accepted and silently dropped.
    for (genvar g = 0; g < NCH; g++) begin : gCh
        tick_channel #(
            .CNT_W      (CNT_W),
            .EXP_W      (EXP_W),
            .DEFAULT_EXP(DEFAULT_EXP)
        ) uChannel (
            .clk_i   (in_clk),
            .rst_ni  (reset_n),
            .cnt_i   (cnt_q),
            .pause_i (pause),
            .wr_i    (apply && (latCh_q == CH_W'(g))),
            .wrExp_i (latExp_q),
            .wrEn_i  (latEn_q),
            .tick_o  (tick[g]),
            .active_o(ch_active[g])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tick_scheduler
// Randomised self-checking bench for tick_scheduler with a period/phase
// reference model. A small prescaler width is used so counter wrap occurs
// often.
// ---------------------------------------------------------------------------
module tb_tick_scheduler;
    import tick_sched_pkg::*;

    localparam int NCH         = 4;
    localparam int CNT_W       = 5;
    localparam int EXP_W       = 5;
    localparam int DEFAULT_EXP = 20;
    localparam int CH_W        = 2;
    localparam int CNT_MOD     = 1 << CNT_W;

    localparam int M_OFF   = 0;
    localparam int M_ALIGN = 1;
    localparam int M_RUN   = 2;

    logic             in_clk    = 1'b0;
    logic             reset_n   = 1'b0;
    logic             pause     = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch    = '0;
    logic [EXP_W-1:0] cfg_exp   = '0;
    logic             cfg_en    = 1'b0;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   ch_active;

    // Reference model state
    int             mCnt;
    int             mMode [NCH];
    int             mExp  [NCH];
    logic [NCH-1:0] mTick;
    bit             mBusy;
    int             mLatCh;
    int             mLatExp;
    bit             mLatEn;

    // Tick interval tracking
    int cycleNo;
    int lastTick [NCH];
    bit clean    [NCH];
    int minP     [NCH];

    int nCompared;
    int nMismatched;

    tick_scheduler #(
        .NCH        (NCH),
        .CNT_W      (CNT_W),
        .EXP_W      (EXP_W),
        .DEFAULT_EXP(DEFAULT_EXP)
    ) dut (
        .in_clk   (in_clk),
        .reset_n  (reset_n),
        .pause    (pause),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_exp  (cfg_exp),
        .cfg_en   (cfg_en),
        .tick     (tick),
        .ch_active(ch_active)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNo, obs, expv);
        end
    endtask

    function automatic int satE(input int e);
        return (e > CNT_W) ? CNT_W : e;
    endfunction

    task automatic modelReset();
        mCnt  = 0;
        mTick = '0;
        mBusy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            mMode[i]    = M_OFF;
            mExp[i]     = satE(DEFAULT_EXP);
            lastTick[i] = -1;
            clean[i]    = 1'b0;
            minP[i]     = 1;
        end
    endtask

    // Predicts the effect of the next rising edge given this cycle's inputs.
    task automatic modelStep(input bit p, input bit v, input int ch, input int e, input bit en);
        logic [NCH-1:0] nt;
        nt = '0;
        for (int i = 0; i < NCH; i++) begin
            int period;
            int phase;
            period = 1 << mExp[i];
            phase  = mCnt % period;
            if (mBusy && mLatCh == i) begin
                if (mLatEn) begin
                    mExp[i]  = mLatExp;
                    mMode[i] = M_ALIGN;
                    clean[i] = 1'b0;
                    if ((1 << mLatExp) < minP[i]) minP[i] = 1 << mLatExp;
                end else begin
                    mMode[i]    = M_OFF;
                    lastTick[i] = -1;
                end
            end else if (!p) begin
                if (mMode[i] == M_ALIGN && phase == 0) begin
                    mMode[i] = M_RUN;
                    nt[i]    = (period == 1);
                end else if (mMode[i] == M_RUN) begin
                    nt[i] = (phase == period - 1);
                end
            end
            if (p) clean[i] = 1'b0;
        end
        mTick = nt;
        if (mBusy) begin
            mBusy = 1'b0;
        end else if (v) begin
            mBusy   = 1'b1;
            mLatCh  = ch;
            mLatExp = satE(e);
            mLatEn  = en;
        end
        if (!p) mCnt = (mCnt + 1) % CNT_MOD;
    endtask

    task automatic compareAll();
        logic [NCH-1:0] act;
        for (int i = 0; i < NCH; i++) act[i] = (mMode[i] == M_RUN);
        checkOutput("tick", 32'(tick), 32'(mTick));
        checkOutput("ch_active", 32'(ch_active), 32'(act));
        checkOutput("cfg_ready", 32'(cfg_ready), 32'(!mBusy));
        checkOutput("cnt", 32'(dut.cnt_q), 32'(mCnt));
        for (int i = 0; i < NCH; i++) begin
            if (tick[i] === 1'b1) begin
                if (lastTick[i] >= 0) begin
                    int iv;
                    iv = cycleNo - lastTick[i];
                    if (clean[i])
                        checkOutput($sformatf("period ch%0d", i), 32'(iv), 32'(1 << mExp[i]));
                    else
                        checkOutput($sformatf("min interval ch%0d", i), 32'(iv),
                                    32'((iv >= minP[i]) ? iv : minP[i]));
                end
                lastTick[i] = cycleNo;
                clean[i]    = 1'b1;
                minP[i]     = 1 << mExp[i];
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check after the next one.
    task automatic applyStimulus(input bit p, input bit v, input int ch, input int e, input bit en);
        pause     = p;
        cfg_valid = v;
        cfg_ch    = ch[CH_W-1:0];
        cfg_exp   = e[EXP_W-1:0];
        cfg_en    = en;
        modelStep(p, v, ch, e, en);
        @(posedge in_clk);
        @(negedge in_clk);
        cycleNo++;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic cfgWrite(input int ch, input int e, input bit en);
        int guard;
        guard = 0;
        while (mBusy && guard < 4) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
            guard++;
        end
        applyStimulus(1'b0, 1'b1, ch, e, en);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Asynchronous reset for one cycle; outputs must clear without a clock.
    task automatic doReset();
        reset_n   = 1'b0;
        pause     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        modelReset();
        checkOutput("rst tick", 32'(tick), 32'(mTick));
        checkOutput("rst ch_active", 32'(ch_active), 32'd0);
        checkOutput("rst cfg_ready", 32'(cfg_ready), 32'(!mBusy));
        checkOutput("rst cnt", 32'(dut.cnt_q), 32'(mCnt));
        @(negedge in_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        int cnt1;
        nCompared   = 0;
        nMismatched = 0;
        cycleNo     = 0;
        modelReset();

        @(negedge in_clk);
        doReset();

        // Single channel, period 8
        cfgWrite(CH_BULLET, 3, 1'b1);
        idle(40);

        // Every-cycle tick plus period 4, then a pause window
        cfgWrite(CH_BULLET, 0, 1'b1);
        cfgWrite(CH_ENEMY, 2, 1'b1);
        idle(10);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
        idle(12);

        // Period change on a running channel
        cfgWrite(CH_DISP, 4, 1'b1);
        idle(21);
        cfgWrite(CH_DISP, 2, 1'b1);
        idle(20);

        // Disable ch1 exactly on its match cycle
        guard = 0;
        while (!(!mBusy && (mCnt % 4) == 2) && guard < 40) begin
            idle(1);
            guard++;
        end
        if (guard >= 40) checkOutput("align wait", 32'(guard), 32'd0);
        cfgWrite(CH_ENEMY, 2, 1'b0);
        checkOutput("disabled active", 32'(ch_active[CH_ENEMY]), 32'd0);
        cnt1 = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (tick[CH_ENEMY] === 1'b1) cnt1++;
        end
        checkOutput("ticks after disable", 32'(cnt1), 32'd0);

        // Full-width period across counter wrap, then a saturating exponent
        cfgWrite(CH_BULLET, CNT_W, 1'b1);
        idle(80);
        cfgWrite(CH_BULLET, 31, 1'b1);
        idle(80);

        // Reset mid-run with three channels active
        cfgWrite(CH_SPARE, 1, 1'b1);
        idle(40);
        doReset();
        idle(40);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                bit p, v, en;
                int ch, e;
                p  = ($urandom_range(0, 9) == 0);
                v  = ($urandom_range(0, 3) == 0);
                ch = int'($urandom_range(0, NCH - 1));
                e  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                                 : int'($urandom_range(0, 4));
                en = ($urandom_range(0, 3) != 0);
                applyStimulus(p, v, ch, e, en);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
